sim_link_responder: RTL and testbench

Far-end responder for the car-to-simulator UART link. It receives the command frame that the car controller transmits, decodes the moving-state and beacon request bits, and periodically transmits a detector-status byte back. The bench and board-level loopback use it in place of the PC simulator, so the car top can be exercised without external tools. It contains its own 8N1 receiver, frame decoder, report scheduler, 8N1 transmitter and link-timeout monitor.

---
 rtl/sim_link_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sim_link_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_link_responder.sv
// Far-end responder for the car-to-simulator UART link.
// Receives 8N1 command bytes, decodes moving-state and beacon requests,
// sends a periodic detector-status byte back and tracks link liveness.
module sim_link_responder #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned REPORT_CYC  = 1_000_000,
  parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic [3:0] detector_in,
  output logic [3:0] moving_state,
  output logic       pl_beacon_pulse,
  output logic       de_beacon_pulse,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       link_alive
);

  localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int unsigned BW       = $clog2(BIT_CYC + 1);
  localparam int unsigned RW       = $clog2(REPORT_CYC + 1);
  localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CYC - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF_CYC - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPORT_CYC - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // receive path
  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     rx_state;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_done, rx_stop_err;
  logic          frame_good;

  // decode history
  logic          pl_hist, de_hist;

  // report scheduler and transmitter
  logic [RW-1:0] rep_cnt;
  logic          rep_wrap;
  logic          rep_pend;
  logic [7:0]    rep_data;
  tx_state_t     tx_state;
  logic [BW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;

  // link monitor
  logic [TW-1:0] link_cnt;
  logic          link_seen;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // 8N1 receiver: mid-bit sampling, glitch rejection on the start bit
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_idx      <= '0;
      rx_shift    <= '0;
      rx_done     <= 1'b0;
      rx_stop_err <= 1'b0;
    end else begin
      rx_done     <= 1'b0;
      rx_stop_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_idx   <= rx_idx + 1'b1;
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt      <= '0;
            rx_done     <= rx_sync;
            rx_stop_err <= !rx_sync;
            rx_state    <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign frame_good = rx_done && (rx_shift[7:6] == 2'b10);

  // Frame decode: header check, moving state, beacon rising-edge pulses
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      moving_state    <= '0;
      pl_beacon_pulse <= 1'b0;
      de_beacon_pulse <= 1'b0;
      frame_valid     <= 1'b0;
      frame_err       <= 1'b0;
      pl_hist         <= 1'b0;
      de_hist         <= 1'b0;
    end else begin
      pl_beacon_pulse <= 1'b0;
      de_beacon_pulse <= 1'b0;
      frame_valid     <= 1'b0;
      frame_err       <= rx_stop_err;
      if (frame_good) begin
        moving_state    <= rx_shift[3:0];
        frame_valid     <= 1'b1;
        pl_beacon_pulse <= rx_shift[4] && !pl_hist;
        de_beacon_pulse <= rx_shift[5] && !de_hist;
        pl_hist         <= rx_shift[4];
        de_hist         <= rx_shift[5];
      end else if (rx_done) begin
        frame_err <= 1'b1;
      end
    end
  end

  // Free-running report period counter
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      rep_cnt <= '0;
    end else if (rep_wrap) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign rep_wrap = (rep_cnt == REP_LAST);

  // 8N1 transmitter with a single pending-request slot; a wrap in the same
  // cycle that a request is consumed re-arms the slot with fresh data
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      rep_pend <= 1'b0;
      rep_data <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (rep_pend) begin
            tx_state <= TX_START;
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_shift <= rep_data;
            rep_pend <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (rep_pend) begin
              tx_state <= TX_START;
              tx       <= 1'b0;
              tx_shift <= rep_data;
              rep_pend <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx       <= 1'b1;
        end
      endcase
      if (rep_wrap) begin
        rep_pend <= 1'b1;
        rep_data <= {4'b0000, detector_in};
      end
    end
  end

  // Link timeout: cleared by each good frame, saturates at the limit
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      link_cnt  <= '0;
      link_seen <= 1'b0;
    end else if (frame_good) begin
      link_cnt  <= '0;
      link_seen <= 1'b1;
    end else if (link_cnt != TO_MAX) begin
      link_cnt <= link_cnt + 1'b1;
    end
  end

  assign link_alive = link_seen && (link_cnt < TO_MAX);

endmodule

// File: tb/tb_sim_link_responder.sv
// Self-checking bench for sim_link_responder: random command frames against
// a byte-level model, a free-running decoder of the report line, timeout and
// mid-frame reset scenarios.
module tb_sim_link_responder;

  localparam int unsigned CLK_FREQ = 320;
  localparam int unsigned BAUD     = 10;
  localparam int unsigned BIT      = 32;
  localparam int unsigned REPORT   = 1000;
  localparam int unsigned TIMEOUT  = 3000;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic [3:0] detector_in = 4'b1010;
  logic [3:0] moving_state;
  logic       pl_beacon_pulse, de_beacon_pulse, frame_valid, frame_err, link_alive;

  sim_link_responder #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .REPORT_CYC(REPORT),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .rx(rx),
    .tx(tx),
    .detector_in(detector_in),
    .moving_state(moving_state),
    .pl_beacon_pulse(pl_beacon_pulse),
    .de_beacon_pulse(de_beacon_pulse),
    .frame_valid(frame_valid),
    .frame_err(frame_err),
    .link_alive(link_alive)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // pulse and liveness observers
  int unsigned cyc = 0;
  int unsigned fv_n = 0, fe_n = 0, pl_n = 0, de_n = 0, stray_n = 0;
  int unsigned last_fv_cyc = 0, alive_fall_cyc = 0;
  bit          alive_q = 1'b0;

  initial begin : pulse_mon
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (frame_valid === 1'b1) begin
        fv_n++;
        last_fv_cyc = cyc;
      end
      if (frame_err === 1'b1) fe_n++;
      if (pl_beacon_pulse === 1'b1) begin
        pl_n++;
        if (frame_valid !== 1'b1) stray_n++;
      end
      if (de_beacon_pulse === 1'b1) begin
        de_n++;
        if (frame_valid !== 1'b1) stray_n++;
      end
      if (alive_q && link_alive !== 1'b1) alive_fall_cyc = cyc;
      alive_q = (link_alive === 1'b1);
    end
  end

  // report-line decoder: expects {4'b0, detector_in} held since the previous
  // report, bits exactly BIT cycles long, one report every REPORT cycles
  initial begin : tx_mon
    logic [9:0]  lv;
    logic [3:0]  exp_d;
    bit          broke, unstable, have_prev;
    int unsigned tcyc, last_rst, fall_cyc, prev_fall, d;
    tcyc = 0; last_rst = 0; prev_fall = 0; have_prev = 1'b0;
    forever begin
      @(negedge sys_clk);
      tcyc++;
      if (rst !== 1'b1) last_rst = tcyc;
      if (rst === 1'b1 && tx === 1'b0) begin
        fall_cyc = tcyc;
        exp_d = detector_in;
        detector_in = 4'($urandom);
        lv = '0; broke = 1'b0; unstable = 1'b0;
        for (int i = 0; i < 10; i++) begin
          for (int k = 0; k < int'(BIT); k++) begin
            if (i != 0 || k != 0) begin
              @(negedge sys_clk);
              tcyc++;
            end
            if (rst !== 1'b1) begin
              broke = 1'b1;
              last_rst = tcyc;
            end
            if (k == 0) lv[i] = tx;
            else if (tx !== lv[i]) unstable = 1'b1;
          end
        end
        if (!broke) begin
          check("tx_start_bit", 32'(lv[0]), 32'd0);
          check("tx_byte", 32'(lv[8:1]), {28'd0, exp_d});
          check("tx_stop_bit", 32'(lv[9]), 32'd1);
          check("tx_bit_len", 32'(unstable), 32'd0);
          if (have_prev) begin
            check("tx_period", fall_cyc - prev_fall, REPORT);
          end else begin
            d = fall_cyc - last_rst;
            check("tx_first_start", 32'(d >= REPORT && d <= REPORT + 3), 32'd1);
          end
          prev_fall = fall_cyc;
          have_prev = 1'b1;
          @(negedge sys_clk);
          tcyc++;
          if (rst !== 1'b1) last_rst = tcyc;
          else check("tx_idle_high", 32'(tx), 32'd1);
        end else begin
          have_prev = 1'b0;
        end
      end
    end
  end

  // byte-level reference model state
  logic [3:0] m_ms = '0;
  logic       m_pl = 1'b0, m_de = 1'b0;

  task automatic send_byte(input logic [7:0] b, input logic stop, input int unsigned per);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (per) @(negedge sys_clk);
    end
    rx = 1'b1;
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic send_and_check(input logic [7:0] b, input logic stop, input int unsigned per);
    int unsigned fv0, fe0, pl0, de0;
    logic ok, e_pl, e_de;
    fv0 = fv_n; fe0 = fe_n; pl0 = pl_n; de0 = de_n;
    ok   = stop && (b[7:6] == 2'b10);
    e_pl = ok && b[4] && !m_pl;
    e_de = ok && b[5] && !m_de;
    send_byte(b, stop, per);
    check("frame_valid_cnt", fv_n - fv0, 32'(ok));
    check("frame_err_cnt", fe_n - fe0, 32'(!ok));
    check("pl_beacon_cnt", pl_n - pl0, 32'(e_pl));
    check("de_beacon_cnt", de_n - de0, 32'(e_de));
    if (ok) begin
      m_ms = b[3:0];
      m_pl = b[4];
      m_de = b[5];
      check("link_alive_after_frame", 32'(link_alive), 32'd1);
    end
    check("moving_state", 32'(moving_state), 32'(m_ms));
  endtask

  initial begin : main
    logic [7:0]  b;
    logic        stop;
    int unsigned k, fv0, fe0;

    rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_moving_state", 32'(moving_state), 32'd0);
    check("rst_pulses", {28'd0, pl_beacon_pulse, de_beacon_pulse, frame_valid, frame_err}, 32'd0);
    check("rst_link_alive", 32'(link_alive), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge sys_clk);

    send_and_check(8'h85, 1'b1, BIT);
    send_and_check(8'h91, 1'b1, BIT);
    send_and_check(8'h91, 1'b1, BIT);
    send_and_check(8'hB1, 1'b1, BIT);
    send_and_check(8'h45, 1'b1, BIT);
    send_and_check(8'h85, 1'b0, BIT);

    // random traffic with slight baud mismatch on the sender side
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 9) < 7) b[7:6] = 2'b10;
      stop = ($urandom_range(0, 9) != 0);
      send_and_check(b, stop, BIT - 1 + $urandom_range(0, 2));
    end

    // link timeout
    send_and_check(8'h82, 1'b1, BIT);
    k = 0;
    while (link_alive === 1'b1 && k < TIMEOUT + 500) begin
      @(negedge sys_clk);
      k++;
    end
    check("timeout_reached", 32'(link_alive), 32'd0);
    @(negedge sys_clk);
    check("timeout_length", alive_fall_cyc - last_fv_cyc, TIMEOUT);
    send_and_check(8'h83, 1'b1, BIT);

    // reset while both directions are mid-frame
    k = 0;
    while (tx !== 1'b0 && k < 3 * REPORT) begin
      @(negedge sys_clk);
      k++;
    end
    check("tx_busy_wait", 32'(tx), 32'd0);
    rx = 1'b0;
    repeat (25) @(negedge sys_clk);
    check("tx_low_before_rst", 32'(tx), 32'd0);
    rst = 1'b0;
    @(negedge sys_clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_moving_state", 32'(moving_state), 32'd0);
    check("midrst_pulses", {28'd0, pl_beacon_pulse, de_beacon_pulse, frame_valid, frame_err}, 32'd0);
    check("midrst_link_alive", 32'(link_alive), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    m_ms = '0; m_pl = 1'b0; m_de = 1'b0;
    fv0 = fv_n; fe0 = fe_n;
    repeat (20 * BIT) @(negedge sys_clk);
    check("post_rst_no_valid", fv_n - fv0, 32'd0);
    check("post_rst_no_err", fe_n - fe0, 32'd0);
    check("post_rst_link_alive", 32'(link_alive), 32'd0);

    send_and_check(8'h91, 1'b1, BIT);
    send_and_check(8'hA7, 1'b1, BIT);
    check("beacon_outside_valid", stray_n, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
